// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Holds the boundary-mode encodings and a constant-safe clog2 for sizing.
package counter_pkg;

    // Boundary behaviour encodings for the SATURATE parameter.
    localparam int COUNT_WRAP = 0;
    localparam int COUNT_SAT  = 1;

    // Ceiling log2, usable in constant expressions.
    // clog2(1) = 0, clog2(2) = 1, clog2(3) = 2, clog2(4) = 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/count_prescaler.sv
// Prescaler: emits one tick every PRESCALE enabled cycles.
// Ports: clk, reset_n (async low), restart (sync zero), enable, tick.
module count_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            // No divider: every enabled cycle is a step.
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, reset_n, restart};
            assign tick      = enable;
        end else begin : g_div
            localparam int PW = clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] div_q;
            logic [PW-1:0] div_d;
            logic          last_hit;

            assign last_hit = enable && (div_q == LAST);

            // restart beats everything; disabled cycles hold.
            always_comb begin
                div_d = div_q;
                if (restart) begin
                    div_d = '0;
                end else if (last_hit) begin
                    div_d = '0;
                end else if (enable) begin
                    div_d = div_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    div_q <= '0;
                end else begin
                    div_q <= div_d;
                end
            end

            assign tick = last_hit;
        end
    endgenerate

endmodule

// File: rtl/updown_counter_param.sv
// Up/down counter, range 0..MAX_VAL, wrap or saturate, with prescaler.
// Ports: clk, reset_n, clear, load, load_val, enable, up_down, flag_clr
//        -> count, tc, at_max, at_min, ovf, unf.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SATURATE = COUNT_WRAP,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             up_down,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam bit SAT = (SATURATE == COUNT_SAT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;

    logic             tick;
    logic             step;
    logic             ovf_set;
    logic             unf_set;
    logic [WIDTH-1:0] load_clamped;

    count_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .restart(clear | load),
        .enable (enable),
        .tick   (tick)
    );

    // clear and load both outrank a step.
    assign step = tick && !clear && !load;

    assign load_clamped = (load_val > MAXV) ? MAXV : load_val;

    assign at_max = (count_q == MAXV);
    assign at_min = (count_q == '0);

    // Boundaries use explicit compares; MAX_VAL may sit below 2**WIDTH-1.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (step) begin
            if (up_down) begin
                if (at_max) begin
                    ovf_set = 1'b1;
                    tc_d    = 1'b1;
                    count_d = SAT ? MAXV : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (at_min) begin
                    unf_set = 1'b1;
                    tc_d    = 1'b1;
                    count_d = SAT ? '0 : MAXV;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    // A new event on the same edge as flag_clr keeps the flag set.
    assign ovf_d = ovf_set | (ovf_q & ~flag_clr);
    assign unf_d = unf_set | (unf_q & ~flag_clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: wrap, saturate and prescale-3 instances
// share one stimulus stream and are scored against a behavioural model.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       enable;
    logic       up_down;
    logic       flag_clr;

    logic [3:0] cnt_w, cnt_s, cnt_p;
    logic       tc_w, tc_s, tc_p;
    logic       mx_w, mx_s, mx_p;
    logic       mn_w, mn_s, mn_p;
    logic       ov_w, ov_s, ov_p;
    logic       un_w, un_s, un_p;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         inst;
        logic [8:0] v;
    } exp_t;

    exp_t sbq[$];

    int   m_cnt[3];
    int   m_ps[3];
    logic m_tc[3];
    logic m_ovf[3];
    logic m_unf[3];
    int   m_sat[3] = '{0, 1, 0};
    int   m_pre[3] = '{1, 1, 3};

    always #5 clk = ~clk;

    updown_counter_param #(
        .WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(1)
    ) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_val(load_val), .enable(enable), .up_down(up_down),
        .flag_clr(flag_clr), .count(cnt_w), .tc(tc_w), .at_max(mx_w),
        .at_min(mn_w), .ovf(ov_w), .unf(un_w)
    );

    updown_counter_param #(
        .WIDTH(4), .MAX_VAL(9), .SATURATE(1), .PRESCALE(1)
    ) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_val(load_val), .enable(enable), .up_down(up_down),
        .flag_clr(flag_clr), .count(cnt_s), .tc(tc_s), .at_max(mx_s),
        .at_min(mn_s), .ovf(ov_s), .unf(un_s)
    );

    updown_counter_param #(
        .WIDTH(4), .MAX_VAL(9), .SATURATE(0), .PRESCALE(3)
    ) u_pre (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_val(load_val), .enable(enable), .up_down(up_down),
        .flag_clr(flag_clr), .count(cnt_p), .tc(tc_p), .at_max(mx_p),
        .at_min(mn_p), .ovf(ov_p), .unf(un_p)
    );

    function automatic logic [8:0] observed(input int i);
        case (i)
            0: return {cnt_w, tc_w, ov_w, un_w, mx_w, mn_w};
            1: return {cnt_s, tc_s, ov_s, un_s, mx_s, mn_s};
            default: return {cnt_p, tc_p, ov_p, un_p, mx_p, mn_p};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_rst();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_ps[i]  = 0;
            m_tc[i]  = 1'b0;
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
    endtask

    // Advance the reference model by one rising edge.
    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            logic so;
            logic su;
            so = 1'b0;
            su = 1'b0;
            m_tc[i] = 1'b0;
            if (clear) begin
                m_cnt[i] = 0;
                m_ps[i]  = 0;
            end else if (load) begin
                m_cnt[i] = (int'(load_val) > 9) ? 9 : int'(load_val);
                m_ps[i]  = 0;
            end else if (enable) begin
                if (m_ps[i] == m_pre[i] - 1) begin
                    m_ps[i] = 0;
                    if (up_down) begin
                        if (m_cnt[i] == 9) begin
                            so = 1'b1;
                            m_tc[i] = 1'b1;
                            m_cnt[i] = m_sat[i] ? 9 : 0;
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end else begin
                        if (m_cnt[i] == 0) begin
                            su = 1'b1;
                            m_tc[i] = 1'b1;
                            m_cnt[i] = m_sat[i] ? 0 : 9;
                        end else begin
                            m_cnt[i] = m_cnt[i] - 1;
                        end
                    end
                end else begin
                    m_ps[i] = m_ps[i] + 1;
                end
            end
            m_ovf[i] = so | (m_ovf[i] & ~flag_clr);
            m_unf[i] = su | (m_unf[i] & ~flag_clr);
        end
    endtask

    task automatic push_model();
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.inst = i;
            e.v = {4'(m_cnt[i]), m_tc[i], m_ovf[i], m_unf[i],
                   (m_cnt[i] == 9), (m_cnt[i] == 0)};
            sbq.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk($sformatf("%s[%0d]", tag, e.inst), observed(e.inst), e.v);
        end
    endtask

    task automatic cyc(input string tag);
        model_edge();
        push_model();
        @(posedge clk);
        #1;
        drain(tag);
    endtask

    task automatic idle();
        clear    = 1'b0;
        load     = 1'b0;
        enable   = 1'b0;
        flag_clr = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        load_val = 4'd0;
        up_down  = 1'b1;
        idle();
        model_rst();
        #12;
        push_model();
        drain("reset");
        chk("reset_min", {8'd0, mn_w}, 9'd1);
        chk("reset_max", {8'd0, mx_w}, 9'd0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Count up ten steps: wrap sees 1..9,0; sat sticks at 9.
        enable  = 1'b1;
        up_down = 1'b1;
        for (int k = 0; k < 9; k++) cyc("wrap_up");
        chk("wrap_at9", {cnt_w, mx_w}, {4'd9, 1'b1});
        cyc("wrap_up");
        chk("wrap_to0", {cnt_w, tc_w, ov_w}, {4'd0, 1'b1, 1'b1});
        chk("sat_hold9", {cnt_s, tc_s, ov_s}, {4'd9, 1'b1, 1'b1});
        chk("pre_3rd", {5'd0, cnt_p}, 9'd3);

        // Second overflow with flag_clr on the same edge keeps ovf.
        idle();
        load     = 1'b1;
        load_val = 4'd9;
        cyc("flag_load");
        load     = 1'b0;
        enable   = 1'b1;
        flag_clr = 1'b1;
        cyc("flag_race");
        chk("ovf_set_wins", {cnt_w, ov_w}, {4'd0, 1'b1});
        idle();
        flag_clr = 1'b1;
        cyc("flag_clr");
        chk("ovf_cleared", {8'd0, ov_w}, 9'd0);
        flag_clr = 1'b0;

        // Saturate-down from 2: 1, 0, 0, 0.
        load     = 1'b1;
        load_val = 4'd2;
        cyc("sat_load");
        load    = 1'b0;
        enable  = 1'b1;
        up_down = 1'b0;
        cyc("sat_dn1");
        cyc("sat_dn2");
        chk("sat_dn2_tc", {cnt_s, tc_s}, {4'd0, 1'b0});
        cyc("sat_dn3");
        chk("sat_dn3_tc", {cnt_s, tc_s}, {4'd0, 1'b1});
        cyc("sat_dn4");
        chk("sat_dn4", {cnt_s, tc_s, un_s, mn_s}, {4'd0, 3'b111});

        // Load clamp, then clear beats load.
        idle();
        load     = 1'b1;
        load_val = 4'd15;
        cyc("clamp");
        chk("clamp9", {5'd0, cnt_w}, 9'd9);
        clear = 1'b1;
        cyc("clr_vs_load");
        chk("clr_wins", {cnt_w, tc_w}, {4'd0, 1'b0});

        // Prescale 3 with a two-cycle enable gap.
        idle();
        up_down = 1'b1;
        enable  = 1'b1;
        cyc("pre_e1");
        cyc("pre_e2");
        chk("pre_e2_hold", {5'd0, cnt_p}, 9'd0);
        cyc("pre_e3");
        chk("pre_e3_step", {5'd0, cnt_p}, 9'd1);
        cyc("pre_e4");
        enable = 1'b0;
        cyc("pre_gap1");
        cyc("pre_gap2");
        enable = 1'b1;
        cyc("pre_e5");
        chk("pre_e5_hold", {5'd0, cnt_p}, 9'd1);
        cyc("pre_e6");
        chk("pre_e6_step", {5'd0, cnt_p}, 9'd2);

        // Asynchronous reset between edges.
        idle();
        load     = 1'b1;
        load_val = 4'd7;
        cyc("pre_async");
        load   = 1'b0;
        enable = 1'b1;
        chk("at7", {5'd0, cnt_w}, 9'd7);
        #2;
        reset_n = 1'b0;
        #1;
        model_rst();
        push_model();
        drain("async_rst");
        @(posedge clk);
        #1;
        drain("rst_hold");
        reset_n = 1'b1;
        enable  = 1'b0;

        // Mixed traffic against the model.
        for (int k = 0; k < 60; k++) begin
            clear    = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 9) == 0);
            load_val = 4'($urandom_range(0, 15));
            enable   = ($urandom_range(0, 3) != 0);
            up_down  = 1'($urandom_range(0, 1));
            flag_clr = ($urandom_range(0, 7) == 0);
            cyc("mixed");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
